// File: rtl/cd_oven_param_loader.sv
// Parameter loader for the Cd oven servo. Host writes fill three shadow
// banks one field at a time. A commit copies a whole shadow bank to its
// live outputs in a single edge. The sequenced mode output is forced to 0
// for a fixed holdoff whenever the requested mode changes or the bank
// currently in use is rewritten.
module cd_oven_param_loader #(
  parameter int FILTER_IO_SIZE = 18,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [1:0]                       wr_bank,
  input  logic [3:0]                       wr_addr,
  input  logic [FILTER_IO_SIZE-1:0]        wr_data,
  input  logic                             commit,
  input  logic [1:0]                       commit_bank,
  output logic                             commit_done,
  input  logic [1:0]                       mode_req,
  output logic [1:0]                       mode,
  output logic                             err,
  input  logic                             err_clr,
  output logic                             PI_on_Cd_1,
  output logic                             is_neg_Cd_1,
  output logic signed [9:0]                NFI_Cd_1,
  output logic signed [9:0]                NI_Cd_1,
  output logic signed [9:0]                NFP_Cd_1,
  output logic signed [9:0]                NP_Cd_1,
  output logic signed [9:0]                ND_Cd_1,
  output logic signed [9:0]                NFD_Cd_1,
  output logic signed [9:0]                NGD_Cd_1,
  output logic signed [FILTER_IO_SIZE-1:0] sp_Cd_1,
  output logic signed [FILTER_IO_SIZE-1:0] offset_Cd_1,
  output logic signed [FILTER_IO_SIZE-1:0] SHDN_Cd_1,
  output logic                             PI_on_Cd_2,
  output logic                             is_neg_Cd_2,
  output logic signed [9:0]                NFI_Cd_2,
  output logic signed [9:0]                NI_Cd_2,
  output logic signed [9:0]                NFP_Cd_2,
  output logic signed [9:0]                NP_Cd_2,
  output logic signed [9:0]                ND_Cd_2,
  output logic signed [9:0]                NFD_Cd_2,
  output logic signed [9:0]                NGD_Cd_2,
  output logic signed [FILTER_IO_SIZE-1:0] sp_Cd_2,
  output logic signed [FILTER_IO_SIZE-1:0] offset_Cd_2,
  output logic signed [FILTER_IO_SIZE-1:0] SHDN_Cd_2,
  output logic                             PI_on_Cd_3,
  output logic                             is_neg_Cd_3,
  output logic signed [9:0]                NFI_Cd_3,
  output logic signed [9:0]                NI_Cd_3,
  output logic signed [9:0]                NFP_Cd_3,
  output logic signed [9:0]                NP_Cd_3,
  output logic signed [9:0]                ND_Cd_3,
  output logic signed [9:0]                NFD_Cd_3,
  output logic signed [9:0]                NGD_Cd_3,
  output logic signed [FILTER_IO_SIZE-1:0] sp_Cd_3,
  output logic signed [FILTER_IO_SIZE-1:0] offset_Cd_3,
  output logic signed [FILTER_IO_SIZE-1:0] SHDN_Cd_3
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  // One complete parameter set for a single mode.
  typedef struct packed {
    logic                      pi_on;
    logic                      is_neg;
    logic [9:0]                nfi;
    logic [9:0]                ni;
    logic [9:0]                nfp;
    logic [9:0]                np;
    logic [9:0]                nd;
    logic [9:0]                nfd;
    logic [9:0]                ngd;
    logic [FILTER_IO_SIZE-1:0] sp;
    logic [FILTER_IO_SIZE-1:0] offset;
    logic [FILTER_IO_SIZE-1:0] shdn;
  } bank_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [1:0]       target_reg, target_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       bank_reg, bank_next;
  logic             live_commit_reg, live_commit_next;
  logic             done_reg, done_next;
  logic             err_reg;
  logic             copy_en;
  logic             copy_err;

  logic wr_fire;
  logic wr_legal;
  logic err_set;

  // Writes are only blocked during the single copy cycle, so the shadow
  // bank being copied cannot change under the copy.
  assign wr_ready = (state_reg != S_COPY);
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_legal = (wr_bank != 2'd0) && (wr_addr <= 4'd10);
  assign err_set  = (wr_fire & ~wr_legal) | copy_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: commits are only serviced from IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (commit)                                          state_next = S_COPY;
        else if (mode_req != target_reg && mode_req != 2'd0) state_next = S_HOLD;
      end
      S_COPY: state_next = live_commit_reg ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (mode_req != target_reg) state_next = (mode_req == 2'd0) ? S_IDLE : S_HOLD;
        else if (cnt_reg == '0)     state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output/datapath control: next values for mode, target, counter and commit bookkeeping.
  always_comb begin
    mode_next        = mode_reg;
    target_next      = target_reg;
    cnt_next         = cnt_reg;
    bank_next        = bank_reg;
    live_commit_next = live_commit_reg;
    done_next        = 1'b0;
    copy_en          = 1'b0;
    copy_err         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (commit) begin
          bank_next        = commit_bank;
          // Rewriting the bank in use: drop the servo off before the copy lands.
          live_commit_next = (commit_bank == mode_reg) && (mode_reg != 2'd0);
          if ((commit_bank == mode_reg) && (mode_reg != 2'd0)) mode_next = 2'd0;
        end else if (mode_req != target_reg) begin
          target_next = mode_req;
          mode_next   = 2'd0;
          if (mode_req != 2'd0) cnt_next = HOLD_LOAD;
        end
      end
      S_COPY: begin
        done_next = 1'b1;
        if (bank_reg != 2'd0) copy_en  = 1'b1;
        else                  copy_err = 1'b1;
        if (live_commit_reg) cnt_next = HOLD_LOAD;
      end
      S_HOLD: begin
        mode_next = 2'd0;
        if (mode_req != target_reg) begin
          // New request restarts the holdoff (or abandons it for mode 0).
          target_next = mode_req;
          cnt_next    = HOLD_LOAD;
        end else if (cnt_reg == '0) begin
          mode_next = target_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg        <= 2'd0;
      target_reg      <= 2'd0;
      cnt_reg         <= '0;
      bank_reg        <= 2'd0;
      live_commit_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      mode_reg        <= mode_next;
      target_reg      <= target_next;
      cnt_reg         <= cnt_next;
      bank_reg        <= bank_next;
      live_commit_reg <= live_commit_next;
      done_reg        <= done_next;
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_reg <= 1'b0;
    else if (err_set)  err_reg <= 1'b1;
    else if (err_clr)  err_reg <= 1'b0;
  end

  assign mode        = mode_reg;
  assign commit_done = done_reg;
  assign err         = err_reg;

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : bank_g
      bank_t shadow_reg;
      bank_t live_reg;

      // Shadow bank: single-field host writes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
        end else if (wr_fire && wr_legal && wr_bank == 2'(gi)) begin
          case (wr_addr)
            4'd0:    shadow_reg.sp     <= wr_data;
            4'd1:    shadow_reg.offset <= wr_data;
            4'd2:    shadow_reg.shdn   <= wr_data;
            4'd3:    shadow_reg.nfi    <= wr_data[9:0];
            4'd4:    shadow_reg.ni     <= wr_data[9:0];
            4'd5:    shadow_reg.nfp    <= wr_data[9:0];
            4'd6:    shadow_reg.np     <= wr_data[9:0];
            4'd7:    shadow_reg.nd     <= wr_data[9:0];
            4'd8:    shadow_reg.nfd    <= wr_data[9:0];
            4'd9:    shadow_reg.ngd    <= wr_data[9:0];
            4'd10: begin
              shadow_reg.pi_on  <= wr_data[0];
              shadow_reg.is_neg <= wr_data[1];
            end
            default: ;
          endcase
        end
      end

      // Live bank: whole-bank atomic copy from the shadow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             live_reg <= '0;
        else if (copy_en && bank_reg == 2'(gi)) live_reg <= shadow_reg;
      end
    end
  endgenerate

  assign PI_on_Cd_1  = bank_g[1].live_reg.pi_on;
  assign is_neg_Cd_1 = bank_g[1].live_reg.is_neg;
  assign NFI_Cd_1    = bank_g[1].live_reg.nfi;
  assign NI_Cd_1     = bank_g[1].live_reg.ni;
  assign NFP_Cd_1    = bank_g[1].live_reg.nfp;
  assign NP_Cd_1     = bank_g[1].live_reg.np;
  assign ND_Cd_1     = bank_g[1].live_reg.nd;
  assign NFD_Cd_1    = bank_g[1].live_reg.nfd;
  assign NGD_Cd_1    = bank_g[1].live_reg.ngd;
  assign sp_Cd_1     = bank_g[1].live_reg.sp;
  assign offset_Cd_1 = bank_g[1].live_reg.offset;
  assign SHDN_Cd_1   = bank_g[1].live_reg.shdn;

  assign PI_on_Cd_2  = bank_g[2].live_reg.pi_on;
  assign is_neg_Cd_2 = bank_g[2].live_reg.is_neg;
  assign NFI_Cd_2    = bank_g[2].live_reg.nfi;
  assign NI_Cd_2     = bank_g[2].live_reg.ni;
  assign NFP_Cd_2    = bank_g[2].live_reg.nfp;
  assign NP_Cd_2     = bank_g[2].live_reg.np;
  assign ND_Cd_2     = bank_g[2].live_reg.nd;
  assign NFD_Cd_2    = bank_g[2].live_reg.nfd;
  assign NGD_Cd_2    = bank_g[2].live_reg.ngd;
  assign sp_Cd_2     = bank_g[2].live_reg.sp;
  assign offset_Cd_2 = bank_g[2].live_reg.offset;
  assign SHDN_Cd_2   = bank_g[2].live_reg.shdn;

  assign PI_on_Cd_3  = bank_g[3].live_reg.pi_on;
  assign is_neg_Cd_3 = bank_g[3].live_reg.is_neg;
  assign NFI_Cd_3    = bank_g[3].live_reg.nfi;
  assign NI_Cd_3     = bank_g[3].live_reg.ni;
  assign NFP_Cd_3    = bank_g[3].live_reg.nfp;
  assign NP_Cd_3     = bank_g[3].live_reg.np;
  assign ND_Cd_3     = bank_g[3].live_reg.nd;
  assign NFD_Cd_3    = bank_g[3].live_reg.nfd;
  assign NGD_Cd_3    = bank_g[3].live_reg.ngd;
  assign sp_Cd_3     = bank_g[3].live_reg.sp;
  assign offset_Cd_3 = bank_g[3].live_reg.offset;
  assign SHDN_Cd_3   = bank_g[3].live_reg.shdn;

endmodule

// File: doc/cd_oven_param_loader.md
# cd_oven_param_loader

Host-side loader for the Cd oven servo parameter banks. It accepts single-field writes from the display/host link into three shadow banks and commits a whole bank atomically to the live bank outputs. It also sequences the display mode request so the servo is forced off (mode 0) for a fixed holdoff whenever the active mode changes or the live bank is rewritten. Its outputs feed the per-mode parameter inputs and `mode` of the Cd oven parameter-select stage.

## Interface
Parameters:
- `FILTER_IO_SIZE`, 18: width of `sp`, `offset`, `SHDN` fields and of `wr_data`.
- `HOLDOFF_CYCLES`, 1024: number of cycles `mode` is held at 0 after a mode change or a live-bank commit; ≥1.
- `CNT_W`, 16: holdoff counter width; `HOLDOFF_CYCLES` ≤ 2^CNT_W.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_valid`  in  1  field write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_bank`  in  2  target shadow bank, 1..3.
- `wr_addr`  in  4  field index.
- `wr_data`  in  FILTER_IO_SIZE  field value.
- `commit`  in  1  level request; held until `commit_done`.
- `commit_bank`  in  2  bank to commit, 1..3; stable while `commit` is high.
- `commit_done`  out  1  one-cycle pulse; commit applied.
- `mode_req`  in  2  display-button mode request.
- `mode`  out  2  sequenced mode to the select stage.
- `err`  out  1  sticky illegal-write flag.
- `err_clr`  in  1  clears `err`.
- For b in 1..3: `PI_on_Cd_b`, `is_neg_Cd_b`  out  1 each; `NFI/NI/NFP/NP/ND/NFD/NGD_Cd_b`  out  10 signed each; `sp/offset/SHDN_Cd_b`  out  FILTER_IO_SIZE signed each. These are the live bank registers.

## Operation
- Field map (`wr_addr`): 0 sp, 1 offset, 2 SHDN, 3 NFI, 4 NI, 5 NFP, 6 NP, 7 ND, 8 NFD, 9 NGD, 10 flags (bit0 PI_on, bit1 is_neg).
  - 10-bit fields take `wr_data[9:0]`; flags take bits [1:0]; upper bits ignored.
- Writes update shadow registers only. Live outputs never change on a write.
- Illegal write (accepted with `wr_addr` 11..15 or `wr_bank` 0): data dropped, `err` set. `err_clr` clears it; set has priority over clear in the same cycle.
- FSM states:
  - IDLE: `wr_ready`=1.
    - If `commit` is high, latch `commit_bank` and go to COPY. If the latched bank equals `mode` (nonzero), drive `mode` to 0 on the same edge.
    - Else, if `mode_req` ≠ target: set target to `mode_req`.
      - `mode_req`=0: drive `mode` to 0 and stay in IDLE.
      - `mode_req` nonzero: drive `mode` to 0, load counter with HOLDOFF_CYCLES−1, go to HOLD.
  - COPY (1 cycle): `wr_ready`=0.
    - Copy all 11 shadow fields of the latched bank to its live outputs in one edge and pulse `commit_done`.
    - If the committed bank was live, load the counter and go to HOLD. Otherwise return to IDLE.
  - HOLD: `wr_ready`=1; `mode`=0.
    - Counter decrements each cycle. At 0: `mode` ← target, go to IDLE.
    - If `mode_req` ≠ target: update target and reload the counter (restart). If `mode_req` becomes 0, exit to IDLE with `mode`=0.
    - `commit` is not serviced in HOLD; it waits, held high, until IDLE.
- A write and a `commit` in the same IDLE cycle: the write lands in shadow and is included in the copy.
- Commit with `commit_bank`=0: no copy, `commit_done` still pulses, `err` set.
- Reset (any time, including mid-COPY/HOLD): all shadow and live fields 0, `mode`=0, target=0, `commit_done`=0, `err`=0, state IDLE, `wr_ready`=1 after release.

## Timing
- Write at edge N: shadow valid after N. No effect on live outputs.
- Commit sampled at edge N (IDLE): live outputs update at edge N+1, `commit_done` high for the cycle following N+1.
- Mode change detected at edge N:
  - `mode`=0 from N.
  - New `mode` appears at edge N+HOLDOFF_CYCLES, so `mode` is 0 for exactly HOLDOFF_CYCLES cycles.
- Live-bank commit at edge N:
  - `mode`=0 from N; copy at N+1.
  - `mode` restored at N+1+HOLDOFF_CYCLES.
  - Live values never change while `mode` equals that bank.
- All outputs registered; no combinational input→output paths.

## Test plan
All scenarios use HOLDOFF_CYCLES=4.
- Reset, then write bank 2 addr 0 = 0x1234 and addr 10 = 0x3, no commit → `sp_Cd_2`=0, `PI_on_Cd_2`=0. Then `commit` with bank 2 → `sp_Cd_2`=0x1234, `PI_on_Cd_2`=1, `is_neg_Cd_2`=1 one edge after the commit edge; `commit_done` single pulse.
- `mode` 0, `mode_req`=1 → `mode`=0 for exactly 4 cycles, then 1. Change `mode_req` to 2 after 2 HOLD cycles → counter restarts; `mode`=2 four cycles after that change.
- `mode`=3, commit bank 3 with new sp 0x00FF → `mode` drops to 0 before `sp_Cd_3` changes, stays 0 for 4 cycles after the copy, then returns to 3. Commit bank 1 while `mode`=3 → `mode` stays 3.
- Write with `wr_valid` in the same cycle `commit` is raised (bank 1 addr 4 = 0x155) → `NI_Cd_1`=0x155 after commit. `wr_ready` is 0 only in the COPY cycle.
- Write with addr 12 → no field changes, `err`=1. `err_clr` → `err`=0. `err_clr` and an illegal write in the same cycle → `err`=1.
- Assert `rst_n` low during HOLD and during COPY → all outputs 0 immediately. After release, `mode_req`=2 held → normal 4-cycle holdoff, then `mode`=2.
